fixed_block_param_scheduler: RTL and testbench

Streams tiled parameters (Q/K/V/projection, MLP weights) from a single shared single-port parameter memory to several consumer weight streams of a ViT encoder block. Each stream's tile sequence is replayed once per token-row tile, because consumers re-consume weights per row tile. A round-robin arbiter shares the memory read port, and a one-entry output register per channel provides valid/ready handshaking. The block sits between the parameter ROM/BRAM and the `weight_*_valid/ready` inputs of the encoder block.

---
 rtl/fixed_block_param_scheduler.sv | 178 +++++++++++++++++
 tb/tb_fixed_block_param_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_block_param_scheduler.sv
// fixed_block_param_scheduler
//
// Streams per-channel parameter tiles out of one shared single-port parameter
// memory. Each channel c walks addresses c*TILES_PER_CH .. c*TILES_PER_CH +
// TILES_PER_CH-1, and replays that walk REPEAT times per pass. A round-robin
// arbiter issues at most one read per cycle. Each channel has a one-word
// output register with a valid/ready handshake.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        begins a pass (accepted only in IDLE)
//   busy         high while a pass is running
//   done         one-cycle pulse when a pass has fully drained
//   mem_rd_en    memory read request
//   mem_addr     memory read address (0 when no request)
//   mem_rd_data  memory read data, valid the cycle after the request
//   out_data     per-channel output word (unpacked array)
//   out_valid    per-channel output valid
//   out_ready    per-channel consumer ready
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; counters are cleared when start arrives
// S_RUN  | arbitrating reads and delivering words to the channels
// S_DONE | single-cycle completion pulse, then back to S_IDLE

module fixed_block_param_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_CH       = 4,
  parameter int TILES_PER_CH = 4,
  parameter int REPEAT       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data [NUM_CH],
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = (TILES_PER_CH > 1) ? $clog2(TILES_PER_CH) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [TW-1:0] TILE_LAST = TW'(TILES_PER_CH - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0]     tile_cnt [NUM_CH];
  logic [RW-1:0]     rep_cnt  [NUM_CH];
  logic [NUM_CH-1:0] inflight;
  logic [NUM_CH-1:0] slot_valid;
  logic [NUM_CH-1:0] finished;
  logic [CW-1:0]     rr_ptr;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] consume;
  logic              grant_vld;
  logic [CW-1:0]     grant_ch;
  logic              pass_complete;

  assign out_valid = slot_valid;
  assign consume   = slot_valid & out_ready;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  // A slot being consumed at this edge counts as empty, so done lands in the
  // cycle right after the last consume.
  assign pass_complete = (&finished) && !(|inflight) &&
                         ((slot_valid & ~out_ready) == '0);

  always_comb begin
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible[c] = (state == S_RUN) && !finished[c] && !inflight[c] && !slot_valid[c];
    end
  end

  // First eligible channel scanning upward from the pointer, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_vld && eligible[(int'(rr_ptr) + i) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant_ch  = CW'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    mem_rd_en = grant_vld;
    mem_addr  = '0;
    if (grant_vld) begin
      mem_addr = ADDR_WIDTH'(int'(grant_ch) * TILES_PER_CH + int'(tile_cnt[grant_ch]));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (pass_complete) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      inflight   <= '0;
      slot_valid <= '0;
      finished   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tile_cnt[c] <= '0;
        rep_cnt[c]  <= '0;
        out_data[c] <= '0;
      end
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && start) begin
        rr_ptr   <= '0;
        finished <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          tile_cnt[c] <= '0;
          rep_cnt[c]  <= '0;
        end
      end

      // Return data belongs to the one channel whose read is in flight; its
      // slot is guaranteed empty because it had to be empty to be granted.
      for (int c = 0; c < NUM_CH; c++) begin
        if (consume[c]) begin
          slot_valid[c] <= 1'b0;
        end
        if (inflight[c]) begin
          out_data[c]   <= mem_rd_data;
          slot_valid[c] <= 1'b1;
          inflight[c]   <= 1'b0;
        end
      end

      if (grant_vld) begin
        inflight[grant_ch] <= 1'b1;
        rr_ptr <= (grant_ch == CH_LAST) ? '0 : grant_ch + CW'(1);
        if (tile_cnt[grant_ch] == TILE_LAST) begin
          tile_cnt[grant_ch] <= '0;
          if (rep_cnt[grant_ch] == REP_LAST) begin
            rep_cnt[grant_ch]  <= '0;
            finished[grant_ch] <= 1'b1;
          end else begin
            rep_cnt[grant_ch] <= rep_cnt[grant_ch] + RW'(1);
          end
        end else begin
          tile_cnt[grant_ch] <= tile_cnt[grant_ch] + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_block_param_scheduler.sv
// Testbench for fixed_block_param_scheduler: default-sized instance checked
// every cycle against a word-count model of the scheduling rules, plus a
// small NUM_CH=1 instance pinned with literal cycle/address expectations.

module tb_fixed_block_param_scheduler;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NC = 4;
  localparam int TP = 4;
  localparam int RP = 8;
  localparam int WORDS = TP * RP;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data [NC];
  logic [NC-1:0] out_valid;
  logic [NC-1:0] out_ready;

  logic          start1;
  logic          busy1, done1, mem_rd_en1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] mem_rd_data1;
  logic [DW-1:0] out_data1 [1];
  logic [0:0]    out_valid1;
  logic [0:0]    out_ready1;

  always #5 clk = ~clk;

  fixed_block_param_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .TILES_PER_CH(TP), .REPEAT(RP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  fixed_block_param_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(1), .TILES_PER_CH(2), .REPEAT(3)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  // Parameter memory with mem[a] = a, one-cycle read latency.
  always @(posedge clk) begin
    mem_rd_data  <= mem_rd_en  ? DW'(mem_addr)  : 32'hDEAD_BEEF;
    mem_rd_data1 <= mem_rd_en1 ? DW'(mem_addr1) : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model of the main instance ----------------
  int cyc = 0;
  int m_state = 0;             // 0 idle, 1 run, 2 done
  int issued   [NC];
  int consumed [NC];
  int lg_cyc   [NC];
  int last_addr[NC];
  int ptr = 0;
  int pass_c0 = 0;
  int done_rel = -1;
  int p_addr[$];
  int p_rel[$];
  int q_ch1[$];

  int d1_c0 = 0;
  int d1_done = -1;
  int d1_last = 0;
  int d1_addr[$];
  int d1_rel[$];

  initial begin
    for (int c = 0; c < NC; c++) begin
      issued[c] = 0; consumed[c] = 0; lg_cyc[c] = 0; last_addr[c] = 0;
    end
  end

  always @(negedge clk) begin
    int  g;
    bit  gv;
    int  ci;
    bit  all_done;
    bit  [NC-1:0] ev;
    gv = 1'b0;
    g  = 0;
    ev = '0;

    chk("busy", busy, m_state == 1);
    chk("done", done, m_state == 2);

    // A channel may have at most one word between grant and consume.
    for (int i = 0; i < NC; i++) begin
      ci = (ptr + i) % NC;
      if (!gv && m_state == 1 && issued[ci] == consumed[ci] && issued[ci] < WORDS) begin
        gv = 1'b1;
        g  = ci;
      end
    end
    chk("mem_rd_en", mem_rd_en, gv);
    if (gv) chk("mem_addr", mem_addr, g * TP + issued[g] % TP);

    for (int c = 0; c < NC; c++) begin
      ev[c] = (issued[c] > consumed[c]) && (cyc >= lg_cyc[c] + 2);
      chk($sformatf("out_valid[%0d]", c), out_valid[c], ev[c]);
      if (ev[c]) chk($sformatf("out_data[%0d]", c), out_data[c], last_addr[c]);
    end

    if (!rst) begin
      if (mem_rd_en1) begin
        d1_addr.push_back(int'(mem_addr1));
        d1_rel.push_back(cyc - d1_c0);
        d1_last = int'(mem_addr1);
      end
      if (out_valid1[0]) chk("d1 out_data", out_data1[0], d1_last);
      if (start1 && !busy1 && !done1) d1_c0 = cyc;
      if (done1) d1_done = cyc - d1_c0;
    end

    if (rst) begin
      m_state = 0;
      ptr = 0;
      for (int c = 0; c < NC; c++) begin
        issued[c] = 0; consumed[c] = 0;
      end
    end else begin
      if (mem_rd_en) begin
        p_addr.push_back(int'(mem_addr));
        p_rel.push_back(cyc - pass_c0);
        if (int'(mem_addr) / TP == 1) q_ch1.push_back(int'(mem_addr));
      end
      if (done) done_rel = cyc - pass_c0;
      for (int c = 0; c < NC; c++) begin
        if (ev[c] && out_ready[c]) consumed[c]++;
      end
      if (gv) begin
        last_addr[g] = g * TP + issued[g] % TP;
        lg_cyc[g] = cyc;
        issued[g]++;
        ptr = (g + 1) % NC;
      end
      case (m_state)
        0: if (start) begin
             m_state = 1;
             ptr = 0;
             pass_c0 = cyc;
             done_rel = -1;
             p_addr.delete();
             p_rel.delete();
             q_ch1.delete();
             for (int c = 0; c < NC; c++) begin
               issued[c] = 0; consumed[c] = 0;
             end
           end
        1: begin
             all_done = 1'b1;
             for (int c = 0; c < NC; c++) if (consumed[c] != WORDS) all_done = 1'b0;
             if (all_done) m_state = 2;
           end
        default: m_state = 0;
      endcase
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd, input string tag);
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (done) break;
      if (rnd) out_ready = NC'($urandom);
    end
    chk({tag, " done reached"}, done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " mem_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    for (int c = 0; c < NC; c++) chk($sformatf("%s out_data[%0d]", tag, c), out_data[c], 0);
  endtask

  task automatic check_pass_count(input string tag);
    chk({tag, " reads"}, p_addr.size(), NC * WORDS);
    if (p_addr.size() > 0) chk({tag, " first addr"}, p_addr[0], 0);
  endtask

  initial begin
    int exp8 [8];
    exp8 = '{0, 4, 8, 12, 1, 5, 9, 13};
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    out_ready = '1;
    out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("power-on reset");
    rst = 1'b0;

    // NUM_CH=1, TILES_PER_CH=2, REPEAT=3
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done1) break;
    end
    chk("d1 done reached", done1, 1'b1);
    @(posedge clk); #1;
    chk("d1 read count", d1_addr.size(), 6);
    for (int i = 0; i < 6 && i < d1_addr.size(); i++) begin
      chk($sformatf("d1 addr #%0d", i), d1_addr[i], i % 2);
      chk($sformatf("d1 grant cycle #%0d", i), d1_rel[i], 1 + 3 * i);
    end
    chk("d1 done cycle", d1_done, 19);

    // full pass, all ready
    pulse_start();
    wait_done(400, 1'b0, "full pass");
    @(posedge clk); #1;
    check_pass_count("full pass");
    for (int i = 0; i < 8 && i < p_addr.size(); i++) begin
      chk($sformatf("full pass addr #%0d", i), p_addr[i], exp8[i]);
    end
    if (p_rel.size() == NC * WORDS) begin
      chk("full pass first grant cycle", p_rel[0], 1);
      chk("full pass last grant cycle", p_rel[NC * WORDS - 1], NC * WORDS);
    end
    chk("full pass done cycle", done_rel, 131);

    // backpressure on ch1 while it holds word 4, with a start pulse in RUN
    out_ready = 4'b1101;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (out_valid[1]) break;
      @(posedge clk); #1;
    end
    chk("bp ch1 valid", out_valid[1], 1'b1);
    chk("bp ch1 data", out_data[1], 4);
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    chk("bp ch1 still valid", out_valid[1], 1'b1);
    chk("bp ch1 data held", out_data[1], 4);
    chk("bp ch1 reads during stall", q_ch1.size(), 1);
    chk("bp others kept going", p_addr.size() > 20, 1'b1);
    out_ready = '1;
    wait_done(600, 1'b0, "backpressure");
    // start in the DONE cycle must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bp ch1 total", q_ch1.size(), WORDS);
    if (q_ch1.size() > 1) chk("bp ch1 resume addr", q_ch1[1], 5);
    check_pass_count("backpressure");
    repeat (3) @(posedge clk);
    #1;
    chk("idle after done-cycle start", busy, 1'b0);

    // three passes with random ready
    for (int p = 0; p < 3; p++) begin
      pulse_start();
      wait_done(3000, 1'b1, $sformatf("random pass %0d", p));
      out_ready = '1;
      @(posedge clk); #1;
      check_pass_count($sformatf("random pass %0d", p));
    end

    // reset mid-pass, restart on the cycle reset releases
    pulse_start();
    repeat ($urandom_range(10, 60)) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("mid-pass reset");
    rst = 1'b0;
    pulse_start();
    wait_done(400, 1'b0, "after reset");
    @(posedge clk); #1;
    check_pass_count("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
